byte_stream_tx: RTL

- Transmit end of the byte-stream interface (data/valid/ready/last) used between CPU-side blocks.
- Accepts a single-word request and serialises it as a framed packet: header byte, 0..DATA_BYTES payload bytes (least significant byte first), then an 8-bit checksum byte carrying last.
- Honours downstream ready backpressure.
- Signals completion to the requester with a one-cycle done pulse.

---
 rtl/byte_stream_tx.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/byte_stream_tx.sv
// byte_stream_tx: transmit end of the byte-stream (data/valid/ready/last) interface.
// A single start strobe latches a payload word and a length, then the block emits
// a framed packet: HEADER_BYTE, L payload bytes (least significant byte first),
// and a checksum byte flagged with last. Downstream backpressure is honoured via
// ready; a one-cycle done pulse follows the checksum transfer.
//
// Ports:
//   clock_i    rising-edge clock
//   clear_ni   asynchronous active-low reset
//   start_i    request strobe, sampled only while idle
//   payload_i  packet data, byte 0 = bits [7:0]
//   length_i   requested payload byte count (clamped to DATA_BYTES)
//   ready_i    downstream accepts the current beat
//   valid_o    data_o/last_o hold a beat
//   data_o     current byte
//   last_o     current beat is the checksum (final) byte
//   busy_o     packet in progress
//   done_o     one-cycle pulse after the checksum beat transfers
module byte_stream_tx #(
    parameter int unsigned DATA_BYTES  = 4,
    parameter logic [7:0]  HEADER_BYTE = 8'h55,
    parameter int unsigned LEN_WIDTH   = 3
) (
    input  logic                    clock_i,
    input  logic                    clear_ni,
    input  logic                    start_i,
    input  logic [8*DATA_BYTES-1:0] payload_i,
    input  logic [LEN_WIDTH-1:0]    length_i,
    input  logic                    ready_i,
    output logic                    valid_o,
    output logic [7:0]              data_o,
    output logic                    last_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam logic [LEN_WIDTH-1:0] MaxLen = LEN_WIDTH'(DATA_BYTES);
    localparam logic [LEN_WIDTH-1:0] One    = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        StIdle,
        StHeader,
        StPayload,
        StChecksum
    } state_e;

    state_e                  state_q, state_d;
    logic [8*DATA_BYTES-1:0] payload_q, payload_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
    logic [7:0]              sum_q, sum_d;
    logic                    valid_q, valid_d;
    logic [7:0]              data_q, data_d;
    logic                    last_q, last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    xfer;
    logic [7:0]              sum_next;

    assign xfer     = valid_q & ready_i;
    // Running checksum including the byte currently on the bus.
    assign sum_next = sum_q + data_q;

    always_comb begin
        state_d   = state_q;
        payload_d = payload_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        valid_d   = valid_q;
        data_d    = data_q;
        last_d    = last_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    payload_d = payload_i;
                    len_d     = (length_i > MaxLen) ? MaxLen : length_i;
                    cnt_d     = '0;
                    sum_d     = HEADER_BYTE;
                    valid_d   = 1'b1;
                    data_d    = HEADER_BYTE;
                    last_d    = 1'b0;
                    state_d   = StHeader;
                end
            end
            StHeader: begin
                if (xfer) begin
                    if (len_q != '0) begin
                        // payload_q is consumed as a shift register, low byte first.
                        data_d    = payload_q[7:0];
                        payload_d = payload_q >> 8;
                        cnt_d     = len_q - One;
                        state_d   = StPayload;
                    end else begin
                        data_d  = sum_q;
                        last_d  = 1'b1;
                        state_d = StChecksum;
                    end
                end
            end
            StPayload: begin
                if (xfer) begin
                    sum_d = sum_next;
                    if (cnt_q != '0) begin
                        data_d    = payload_q[7:0];
                        payload_d = payload_q >> 8;
                        cnt_d     = cnt_q - One;
                    end else begin
                        data_d  = sum_next;
                        last_d  = 1'b1;
                        state_d = StChecksum;
                    end
                end
            end
            StChecksum: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    data_d  = '0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock_i or negedge clear_ni) begin
        if (!clear_ni) begin
            state_q   <= StIdle;
            payload_q <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            payload_q <= payload_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule
